timer_multi_mode: RTL and testbench

Parametrised successor to the single-mode H:M:S countdown timer. Runs on the system clock and uses a 1 Hz enable pulse from the clock divider. Supports countdown and count-up (stopwatch) modes, preset retention with reload, optional auto-reload periodic operation, and explicit expiry outputs. Sits between the debouncers/switches and the seven-segment display driver.

---
 rtl/timer_pkg.sv | 24 ++
 rtl/timer_hms_step.sv | 52 +++++
 rtl/timer_multi_mode.sv | 132 +++++++++++++
 tb/tb_timer_multi_mode.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared state encoding, field limits and H:M:S value type for the multi-mode timer.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;

  // Hour field sized for the widest supported HOUR_W; narrower builds keep the top bits zero.
  localparam int unsigned HOUR_W_MAX = 8;

  typedef struct packed {
    logic [HOUR_W_MAX-1:0] hour;
    logic [5:0]            min;
    logic [5:0]            sec;
  } hms_t;

endpackage

// File: rtl/timer_hms_step.sv
// Combinational one-second step of an H:M:S value, up or down, with terminal detection.
module timer_hms_step
  import timer_pkg::*;
#(
  parameter int unsigned HOUR_MAX = 12
) (
  input  logic up,
  input  hms_t cur,
  output hms_t nxt,
  output logic terminal
);

  localparam logic [HOUR_W_MAX-1:0] HMAX = HOUR_W_MAX'(HOUR_MAX);
  localparam logic [HOUR_W_MAX-1:0] HONE = HOUR_W_MAX'(1);
  localparam hms_t TOP = '{hour: HMAX, min: MIN_MAX, sec: SEC_MAX};

  always_comb begin
    nxt      = cur;
    terminal = 1'b0;
    if (up) begin
      // Count-up saturates at the top value rather than wrapping.
      if (cur != TOP) begin
        if (cur.sec != SEC_MAX) begin
          nxt.sec = cur.sec + 6'd1;
        end else begin
          nxt.sec = '0;
          if (cur.min != MIN_MAX) begin
            nxt.min = cur.min + 6'd1;
          end else begin
            nxt.min  = '0;
            nxt.hour = (cur.hour >= HMAX) ? '0 : cur.hour + HONE;
          end
        end
      end
      terminal = (nxt == TOP);
    end else begin
      if (cur.sec != '0) begin
        nxt.sec = cur.sec - 6'd1;
      end else begin
        nxt.sec = SEC_MAX;
        if (cur.min != '0) begin
          nxt.min = cur.min - 6'd1;
        end else begin
          nxt.min  = MIN_MAX;
          nxt.hour = (cur.hour == '0) ? HMAX : cur.hour - HONE;
        end
      end
      terminal = (nxt == '0);
    end
  end

endmodule

// File: rtl/timer_multi_mode.sv
// Multi-mode H:M:S timer: countdown / stopwatch with preset reload and expiry outputs.
module timer_multi_mode
  import timer_pkg::*;
#(
  parameter int unsigned HOUR_MAX    = 12,
  parameter int unsigned HOUR_W      = 5,
  parameter int unsigned AUTO_RELOAD = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              tick_1Hz,
  input  logic              mode_in,
  input  logic              dir_in,
  input  logic              start_stop,
  input  logic              hour_in,
  input  logic              min_in,
  input  logic              sec_in,
  output logic [HOUR_W-1:0] hour_out,
  output logic [5:0]        min_out,
  output logic [5:0]        sec_out,
  output logic [2:0]        state_out,
  output logic              expired,
  output logic              alarm_pulse
);

  generate
    if ((2 ** HOUR_W) <= HOUR_MAX || HOUR_W > HOUR_W_MAX) begin : g_bad_hour_w
      $error("timer_multi_mode: HOUR_W cannot hold HOUR_MAX");
    end
  endgenerate

  localparam logic [HOUR_W_MAX-1:0] HMAX   = HOUR_W_MAX'(HOUR_MAX);
  localparam logic [HOUR_W_MAX-1:0] HONE   = HOUR_W_MAX'(1);
  localparam logic                  RELOAD = (AUTO_RELOAD != 0);

  state_t st_q, st_d;
  hms_t   val_q, val_d, pre_q, pre_d, step_nxt;
  logic   dir_q, dir_d, alarm_q, alarm_d, exp_q, exp_d, step_term;

  timer_hms_step #(.HOUR_MAX(HOUR_MAX)) u_step (
    .up       (dir_q),
    .cur      (val_q),
    .nxt      (step_nxt),
    .terminal (step_term)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q    <= IDLE;
      val_q   <= '0;
      pre_q   <= '0;
      dir_q   <= 1'b0;
      alarm_q <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      val_q   <= val_d;
      pre_q   <= pre_d;
      dir_q   <= dir_d;
      alarm_q <= alarm_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    val_d   = val_q;
    pre_d   = pre_q;
    dir_d   = dir_q;
    alarm_d = 1'b0;
    if (!mode_in) begin
      st_d  = IDLE;
      val_d = '0;
      pre_d = '0;
      dir_d = 1'b0;
    end else begin
      unique case (st_q)
        IDLE: begin
          val_d = '0;
          st_d  = SET;
        end
        SET: begin
          if (start_stop) begin
            pre_d = val_q;
            dir_d = dir_in;
            if (dir_in || val_q != '0) st_d = RUN;
          end
          // Field buttons stay live whenever the value remains in SET, including the zero guard.
          if (st_d == SET) begin
            if (hour_in) val_d.hour = (val_q.hour >= HMAX) ? '0 : val_q.hour + HONE;
            if (min_in)  val_d.min  = (val_q.min >= MIN_MAX) ? '0 : val_q.min + 6'd1;
            if (sec_in)  val_d.sec  = (val_q.sec >= SEC_MAX) ? '0 : val_q.sec + 6'd1;
          end
        end
        RUN: begin
          if (!start_stop) begin
            st_d = PAUSE;
          end else if (tick_1Hz) begin
            if (RELOAD && !dir_q && val_q == '0) begin
              val_d = pre_q;
            end else begin
              val_d = step_nxt;
              if (step_term) begin
                alarm_d = 1'b1;
                if (dir_q || !RELOAD) st_d = DONE;
              end
            end
          end
        end
        PAUSE: begin
          if (start_stop) st_d = RUN;
        end
        DONE: begin
          if (!start_stop) begin
            st_d  = SET;
            val_d = pre_q;
          end
        end
        default: st_d = IDLE;
      endcase
    end
    exp_d = (st_d == DONE);
  end

  assign hour_out    = val_q.hour[HOUR_W-1:0];
  assign min_out     = val_q.min;
  assign sec_out     = val_q.sec;
  assign state_out   = st_q;
  assign expired     = exp_q;
  assign alarm_pulse = alarm_q;

endmodule

// File: tb/tb_timer_multi_mode.sv
// Self-checking bench for timer_multi_mode: directed scenarios plus random stimulus vs a seconds-based model.
module tb_timer_multi_mode;

  localparam int HM   = 12;
  localparam int MAXT = HM * 3600 + 59 * 60 + 59;

  logic clk = 1'b0, resetn = 1'b0, tick_1Hz = 1'b0, mode_in = 1'b0, dir_in = 1'b0;
  logic start_stop = 1'b0, hour_in = 1'b0, min_in = 1'b0, sec_in = 1'b0;
  logic [4:0] hour_out, hour_ar;
  logic [5:0] min_out, sec_out, min_ar, sec_ar;
  logic [2:0] state_out, state_ar;
  logic expired, expired_ar, alarm_pulse, alarm_ar;
  logic [21:0] got, got_ar;

  int errors = 0;
  int checks = 0;

  // reference model: value kept as total seconds
  int m_st = 0, m_t = 0, m_pre = 0, m_dir = 0, m_alarm = 0;

  always #5 clk = ~clk;

  timer_multi_mode #(.HOUR_MAX(12), .HOUR_W(5), .AUTO_RELOAD(0)) dut (
    .clk(clk), .resetn(resetn), .tick_1Hz(tick_1Hz), .mode_in(mode_in), .dir_in(dir_in),
    .start_stop(start_stop), .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
    .hour_out(hour_out), .min_out(min_out), .sec_out(sec_out), .state_out(state_out),
    .expired(expired), .alarm_pulse(alarm_pulse));

  timer_multi_mode #(.HOUR_MAX(12), .HOUR_W(5), .AUTO_RELOAD(1)) dut_ar (
    .clk(clk), .resetn(resetn), .tick_1Hz(tick_1Hz), .mode_in(mode_in), .dir_in(dir_in),
    .start_stop(start_stop), .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
    .hour_out(hour_ar), .min_out(min_ar), .sec_out(sec_ar), .state_out(state_ar),
    .expired(expired_ar), .alarm_pulse(alarm_ar));

  assign got    = {state_out, hour_out, min_out, sec_out, expired, alarm_pulse};
  assign got_ar = {state_ar, hour_ar, min_ar, sec_ar, expired_ar, alarm_ar};

  function automatic logic [21:0] pack(int st, int h, int m, int s, int e, int a);
    return {3'(st), 5'(h), 6'(m), 6'(s), 1'(e), 1'(a)};
  endfunction

  function automatic string fmt(logic [21:0] v);
    return $sformatf("st=%0d %0d:%0d:%0d exp=%0b al=%0b", v[21:19], v[18:14], v[13:8], v[7:2], v[1], v[0]);
  endfunction

  function automatic logic [21:0] model_out();
    return pack(m_st, m_t / 3600, (m_t / 60) % 60, m_t % 60, (m_st == 4) ? 1 : 0, m_alarm);
  endfunction

  task automatic model_edge();
    int h, m, s;
    m_alarm = 0;
    if (!resetn || !mode_in) begin
      m_st = 0; m_t = 0; m_pre = 0; m_dir = 0;
      return;
    end
    case (m_st)
      0: begin m_st = 1; m_t = 0; end
      1: begin
        if (start_stop) begin
          m_pre = m_t; m_dir = dir_in;
          if (dir_in || m_t != 0) m_st = 2;
        end
        if (m_st == 1) begin
          h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
          if (hour_in) h = (h + 1) % (HM + 1);
          if (min_in)  m = (m + 1) % 60;
          if (sec_in)  s = (s + 1) % 60;
          m_t = h * 3600 + m * 60 + s;
        end
      end
      2: begin
        if (!start_stop) m_st = 3;
        else if (tick_1Hz) begin
          if (m_dir == 0) begin
            m_t = m_t - 1;
            if (m_t == 0) begin m_alarm = 1; m_st = 4; end
          end else begin
            if (m_t < MAXT) m_t = m_t + 1;
            if (m_t == MAXT) begin m_alarm = 1; m_st = 4; end
          end
        end
      end
      3: if (start_stop) m_st = 2;
      4: if (!start_stop) begin m_st = 1; m_t = m_pre; end
      default: m_st = 0;
    endcase
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; mode_in = 1'b0; dir_in = 1'b0; start_stop = 1'b0; tick_1Hz = 1'b0;
    hour_in = 1'b0; min_in = 1'b0; sec_in = 1'b0;
    repeat (2) clk_step();
    resetn = 1'b1;
    clk_step();
  endtask

  task automatic enter_set();
    mode_in = 1'b1;
    clk_step();
  endtask

  task automatic set_value(int h, int m, int s);
    int n;
    n = (h > m) ? h : m;
    n = (n > s) ? n : s;
    for (int i = 0; i < n; i++) begin
      hour_in = (i < h); min_in = (i < m); sec_in = (i < s);
      clk_step();
    end
    hour_in = 1'b0; min_in = 1'b0; sec_in = 1'b0;
  endtask

  task automatic do_tick();
    tick_1Hz = 1'b1;
    clk_step();
    tick_1Hz = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) clk_step();
    checks++;
    if (got !== pack(0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset got %s want %s", fmt(got), fmt(pack(0, 0, 0, 0, 0, 0)));
    end
    resetn = 1'b1;
    clk_step();
  endtask

  task automatic test_countdown();
    logic [21:0] w;
    do_reset(); enter_set(); set_value(0, 1, 5);
    checks++;
    if (got !== pack(1, 0, 1, 5, 0, 0)) begin
      errors++; $display("FAIL cd_set got %s want %s", fmt(got), fmt(pack(1, 0, 1, 5, 0, 0)));
    end
    dir_in = 1'b0; start_stop = 1'b1;
    do_tick();  // tick on the RUN-entry edge must not count
    checks++;
    if (got !== pack(2, 0, 1, 5, 0, 0)) begin
      errors++; $display("FAIL cd_start got %s want %s", fmt(got), fmt(pack(2, 0, 1, 5, 0, 0)));
    end
    for (int k = 1; k <= 65; k++) begin
      do_tick();
      w = pack((k == 65) ? 4 : 2, 0, (65 - k) / 60, (65 - k) % 60, (k == 65) ? 1 : 0, (k == 65) ? 1 : 0);
      checks++;
      if (got !== w) begin errors++; $display("FAIL cd_tick%0d got %s want %s", k, fmt(got), fmt(w)); end
      clk_step();
    end
    checks++;
    if (got !== pack(4, 0, 0, 0, 1, 0)) begin
      errors++; $display("FAIL cd_done got %s want %s", fmt(got), fmt(pack(4, 0, 0, 0, 1, 0)));
    end
    start_stop = 1'b0;
    clk_step();
    checks++;
    if (got !== pack(1, 0, 1, 5, 0, 0)) begin
      errors++; $display("FAIL cd_restore got %s want %s", fmt(got), fmt(pack(1, 0, 1, 5, 0, 0)));
    end
  endtask

  task automatic test_pause();
    do_reset(); enter_set(); set_value(1, 0, 0);
    dir_in = 1'b0; start_stop = 1'b1; clk_step();
    do_tick();
    checks++;
    if (got !== pack(2, 0, 59, 59, 0, 0)) begin
      errors++; $display("FAIL pause_tick got %s want %s", fmt(got), fmt(pack(2, 0, 59, 59, 0, 0)));
    end
    start_stop = 1'b0;
    do_tick();
    dir_in = 1'b1;
    do_tick();
    checks++;
    if (got !== pack(3, 0, 59, 59, 0, 0)) begin
      errors++; $display("FAIL pause_hold got %s want %s", fmt(got), fmt(pack(3, 0, 59, 59, 0, 0)));
    end
    start_stop = 1'b1; clk_step();
    do_tick();
    checks++;
    if (got !== pack(2, 0, 59, 58, 0, 0)) begin
      errors++; $display("FAIL pause_resume got %s want %s", fmt(got), fmt(pack(2, 0, 59, 58, 0, 0)));
    end
    start_stop = 1'b0; clk_step();
    mode_in = 1'b0; clk_step();
    checks++;
    if (got !== pack(0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL pause_idle got %s want %s", fmt(got), fmt(pack(0, 0, 0, 0, 0, 0)));
    end
  endtask

  task automatic test_count_up();
    do_reset(); enter_set(); set_value(12, 59, 58);
    dir_in = 1'b1; start_stop = 1'b1; clk_step();
    dir_in = 1'b0;
    do_tick();
    checks++;
    if (got !== pack(4, 12, 59, 59, 1, 1)) begin
      errors++; $display("FAIL up_top got %s want %s", fmt(got), fmt(pack(4, 12, 59, 59, 1, 1)));
    end
    clk_step();
    do_tick();
    checks++;
    if (got !== pack(4, 12, 59, 59, 1, 0)) begin
      errors++; $display("FAIL up_sat got %s want %s", fmt(got), fmt(pack(4, 12, 59, 59, 1, 0)));
    end
    start_stop = 1'b0; clk_step();
    checks++;
    if (got !== pack(1, 12, 59, 58, 0, 0)) begin
      errors++; $display("FAIL up_restore got %s want %s", fmt(got), fmt(pack(1, 12, 59, 58, 0, 0)));
    end
  endtask

  task automatic test_auto_reload();
    int exp_s[5] = '{1, 0, 2, 1, 0};
    int exp_a[5] = '{0, 1, 0, 0, 1};
    logic [21:0] w;
    do_reset(); enter_set(); set_value(0, 0, 2);
    dir_in = 1'b0; start_stop = 1'b1; clk_step();
    for (int k = 0; k < 5; k++) begin
      do_tick();
      w = pack(2, 0, 0, exp_s[k], 0, exp_a[k]);
      checks++;
      if (got_ar !== w) begin errors++; $display("FAIL ar_tick%0d got %s want %s", k, fmt(got_ar), fmt(w)); end
      clk_step();
      w = pack(2, 0, 0, exp_s[k], 0, 0);
      checks++;
      if (got_ar !== w) begin errors++; $display("FAIL ar_gap%0d got %s want %s", k, fmt(got_ar), fmt(w)); end
    end
  endtask

  task automatic test_set_rules();
    do_reset(); enter_set();
    dir_in = 1'b0; start_stop = 1'b1; clk_step();
    checks++;
    if (got !== pack(1, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL set_guard got %s want %s", fmt(got), fmt(pack(1, 0, 0, 0, 0, 0)));
    end
    start_stop = 1'b0;
    set_value(12, 0, 0);
    checks++;
    if (got !== pack(1, 12, 0, 0, 0, 0)) begin
      errors++; $display("FAIL set_h12 got %s want %s", fmt(got), fmt(pack(1, 12, 0, 0, 0, 0)));
    end
    set_value(1, 0, 0);
    checks++;
    if (got !== pack(1, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL set_hwrap got %s want %s", fmt(got), fmt(pack(1, 0, 0, 0, 0, 0)));
    end
    set_value(3, 59, 59);
    min_in = 1'b1; sec_in = 1'b1; clk_step(); min_in = 1'b0; sec_in = 1'b0;
    checks++;
    if (got !== pack(1, 3, 0, 0, 0, 0)) begin
      errors++; $display("FAIL set_mswrap got %s want %s", fmt(got), fmt(pack(1, 3, 0, 0, 0, 0)));
    end
    start_stop = 1'b1; clk_step();
    min_in = 1'b1; hour_in = 1'b1; clk_step(); min_in = 1'b0; hour_in = 1'b0;
    checks++;
    if (got !== pack(2, 3, 0, 0, 0, 0)) begin
      errors++; $display("FAIL run_btn got %s want %s", fmt(got), fmt(pack(2, 3, 0, 0, 0, 0)));
    end
  endtask

  task automatic test_async_reset();
    do_reset(); enter_set(); set_value(0, 30, 0);
    dir_in = 1'b0; start_stop = 1'b1; clk_step();
    checks++;
    if (got !== pack(2, 0, 30, 0, 0, 0)) begin
      errors++; $display("FAIL ar_run got %s want %s", fmt(got), fmt(pack(2, 0, 30, 0, 0, 0)));
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (got !== pack(0, 0, 0, 0, 0, 0) || got_ar !== pack(0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL async_reset got %s want %s", fmt(got), fmt(pack(0, 0, 0, 0, 0, 0)));
    end
    clk_step();
    resetn = 1'b1;
    clk_step();
  endtask

  task automatic test_random();
    logic [21:0] w;
    do_reset(); enter_set();
    for (int c = 0; c < 3000; c++) begin
      mode_in  = ($urandom_range(299) != 0);
      if ($urandom_range(15) == 0) start_stop = ~start_stop;
      dir_in   = 1'($urandom_range(1));
      tick_1Hz = ($urandom_range(2) == 0);
      hour_in  = ($urandom_range(49) == 0);
      min_in   = ($urandom_range(9) == 0);
      sec_in   = ($urandom_range(3) == 0);
      clk_step();
      w = model_out();
      checks++;
      if (got !== w) begin errors++; $display("FAIL random_c%0d got %s want %s", c, fmt(got), fmt(w)); end
    end
    tick_1Hz = 1'b0; hour_in = 1'b0; min_in = 1'b0; sec_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_count_up();
    test_auto_reload();
    test_set_rules();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
